// File: rtl/quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen
//
// Quadrature encoder emulator. A signed step count and a step period are
// turned into A/B quadrature waveforms. The block keeps its own running count
// of emitted steps, so software can compare it against a decoder's count.
//
// Ports:
//   clk_50      - system clock (50 MHz)
//   reset_n     - asynchronous reset, active low
//   start       - one-cycle command strobe, only honoured when idle
//   steps       - signed step count (positive: A leads B, negative: B leads A)
//   step_period - clk_50 cycles between successive A/B edges, latched at start
//   abort       - stops a running move without emitting further edges
//   pos_clear   - synchronous clear of position (wins over a coincident step)
//   a, b        - registered quadrature outputs
//   busy        - high while a move is running
//   done        - one-cycle pulse on normal completion of a move
//   direction   - direction of the most recently started move (1 = reverse)
//   position    - signed, wrapping count of emitted steps
// ---------------------------------------------------------------------------
module quad_encoder_gen #(
    parameter int WIDTH      = 32,
    parameter int MIN_PERIOD = 2
) (
    input  logic                    clk_50,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] steps,
    input  logic        [WIDTH-1:0] step_period,
    input  logic                    abort,
    input  logic                    pos_clear,
    output logic                    a,
    output logic                    b,
    output logic                    busy,
    output logic                    done,
    output logic                    direction,
    output logic signed [WIDTH-1:0] position
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

    logic [1:0]              state_q, state_d;
    logic                    a_q, a_d;
    logic                    b_q, b_d;
    logic                    done_q, done_d;
    logic                    dir_q, dir_d;
    logic signed [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0]        remaining_q, remaining_d;
    logic [WIDTH-1:0]        period_q, period_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;

    logic                    step_en;
    logic [WIDTH-1:0]        abs_steps;
    logic [WIDTH-1:0]        clamped_period;
    logic [1:0]              next_ba;

    // Magnitude is taken as unsigned so the most negative count still works.
    always_comb begin
        abs_steps = steps[WIDTH-1] ? (~steps + ONE) : steps;
        clamped_period = (step_period < MIN_P) ? MIN_P : step_period;
    end

    // Gray-code neighbour of the current {b,a} phase in the move direction;
    // exactly one output bit differs from the current phase.
    always_comb begin
        next_ba = {b_q, a_q};
        if (!dir_q) begin
            case ({b_q, a_q})
                2'b00:   next_ba = 2'b01;
                2'b01:   next_ba = 2'b11;
                2'b11:   next_ba = 2'b10;
                default: next_ba = 2'b00;
            endcase
        end else begin
            case ({b_q, a_q})
                2'b00:   next_ba = 2'b10;
                2'b10:   next_ba = 2'b11;
                2'b11:   next_ba = 2'b01;
                default: next_ba = 2'b00;
            endcase
        end
    end

    // Move sequencing: command acceptance, period counting and step issue.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        step_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (steps != ZERO) begin
                        state_d     = RUN;
                        remaining_d = abs_steps;
                        period_d    = clamped_period;
                        dir_d       = steps[WIDTH-1];
                        cnt_d       = ZERO;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == period_q - ONE) begin
                    step_en     = 1'b1;
                    cnt_d       = ZERO;
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs follow the emitted steps; pos_clear overrides a coincident step.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        pos_d = pos_q;
        if (step_en) begin
            a_d   = next_ba[0];
            b_d   = next_ba[1];
            pos_d = dir_q ? (pos_q - ONE) : (pos_q + ONE);
        end
        if (pos_clear) begin
            pos_d = '0;
        end
    end

    // State registers; reset returns everything, including the phase, to zero.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            done_q      <= 1'b0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
            remaining_q <= '0;
            period_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            done_q      <= done_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign direction = dir_q;
    assign position  = pos_q;

endmodule
